// File: rtl/sr_ff_bank.sv
// Bank of WIDTH clocked bistable cells with a global SR/JK/D/T mode.
// SR illegal inputs resolve by a fixed policy and are logged per channel.
module sr_ff_bank #(
    parameter int WIDTH     = 8,
    parameter int SR_POLICY = 0,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic [WIDTH-1:0]     s,
    input  logic [WIDTH-1:0]     r,
    input  logic                 err_clr,
    output logic [WIDTH-1:0]     q,
    output logic [WIDTH-1:0]     qn,
    output logic [WIDTH-1:0]     err_vec,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        M_SR = 2'b00,
        M_JK = 2'b01,
        M_D  = 2'b10,
        M_T  = 2'b11
    } mode_e;

    logic [WIDTH-1:0]     r_q;
    logic [WIDTH-1:0]     r_err_vec;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic [WIDTH-1:0]     w_q_next;
    logic [WIDTH-1:0]     w_sr_both;
    logic [WIDTH-1:0]     w_hold;
    logic [WIDTH-1:0]     w_illegal;
    logic                 w_any_illegal;
    logic                 w_cnt_sat;

    // Value taken by a channel when S=R=1 in SR mode; unknown policies hold
    always_comb begin
        w_sr_both = r_q;
        if (SR_POLICY == 1) begin
            w_sr_both = '1;
        end else if (SR_POLICY == 2) begin
            w_sr_both = '0;
        end
    end

    assign w_hold = r_q & ~s & ~r;

    always_comb begin
        w_q_next = r_q;
        unique case (mode_e'(mode))
            M_SR: w_q_next = (s & ~r) | w_hold | (s & r & w_sr_both);
            M_JK: w_q_next = (s & ~r) | w_hold | (s & r & ~r_q);
            M_D:  w_q_next = s;
            M_T:  w_q_next = r_q ^ s;
            default: w_q_next = r_q;
        endcase
    end

    assign w_illegal     = (en && mode == M_SR) ? (s & r) : '0;
    assign w_any_illegal = |w_illegal;
    assign w_cnt_sat     = &r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q       <= '0;
            r_err_vec <= '0;
            r_err_cnt <= '0;
        end else begin
            if (en) begin
                r_q <= w_q_next;
            end
            // A fresh illegal event on the clearing edge survives the clear
            if (err_clr) begin
                r_err_vec <= w_illegal;
                r_err_cnt <= ERR_CNT_W'(w_any_illegal);
            end else begin
                r_err_vec <= r_err_vec | w_illegal;
                if (w_any_illegal && !w_cnt_sat) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
            end
        end
    end

    assign q       = r_q;
    assign qn      = ~r_q;
    assign err_vec = r_err_vec;
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Bench for sr_ff_bank: three instances (policies 0/1/2) against a
// behavioural per-channel model, directed scenarios plus random traffic.
module tb_sr_ff_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [3:0] s;
    logic [3:0] r;
    logic       err_clr;

    logic [3:0] q[3];
    logic [3:0] qn[3];
    logic [3:0] ev[3];
    logic [3:0] ec[3];

    logic [3:0] m_q[3];
    logic [3:0] m_vec[3];
    int         m_cnt[3];

    int n_chk  = 0;
    int n_pass = 0;
    bit qn_on  = 1'b0;

    always #5 clk = ~clk;

    sr_ff_bank #(.WIDTH(4), .SR_POLICY(0), .ERR_CNT_W(4)) u_p0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .s(s), .r(r),
        .err_clr(err_clr), .q(q[0]), .qn(qn[0]), .err_vec(ev[0]),
        .err_cnt(ec[0])
    );
    sr_ff_bank #(.WIDTH(4), .SR_POLICY(1), .ERR_CNT_W(4)) u_p1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .s(s), .r(r),
        .err_clr(err_clr), .q(q[1]), .qn(qn[1]), .err_vec(ev[1]),
        .err_cnt(ec[1])
    );
    sr_ff_bank #(.WIDTH(4), .SR_POLICY(2), .ERR_CNT_W(4)) u_p2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .s(s), .r(r),
        .err_clr(err_clr), .q(q[2]), .qn(qn[2]), .err_vec(ev[2]),
        .err_cnt(ec[2])
    );

    // Next state of one channel from the truth tables of each mode
    function automatic bit next_bit(int pol, int md, bit b, bit sv, bit rv);
        case (md)
            0: begin
                if (sv && rv) return (pol == 1) ? 1'b1 : (pol == 2) ? 1'b0 : b;
                if (sv) return 1'b1;
                if (rv) return 1'b0;
                return b;
            end
            1: begin
                if (sv && rv) return !b;
                if (sv) return 1'b1;
                if (rv) return 1'b0;
                return b;
            end
            2: return sv;
            default: return sv ? !b : b;
        endcase
    endfunction

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            int nill;
            logic [3:0] bad;
            bad = 4'b0000;
            if (rst) begin
                m_q[k]   = 4'b0000;
                m_vec[k] = 4'b0000;
                m_cnt[k] = 0;
                continue;
            end
            if (en && mode == 2'b00) bad = s & r;
            nill = 0;
            for (int i = 0; i < 4; i++) if (bad[i]) nill++;
            if (en)
                for (int i = 0; i < 4; i++)
                    m_q[k][i] = next_bit(k, int'(mode), m_q[k][i], s[i], r[i]);
            if (err_clr) begin
                m_vec[k] = bad;
                m_cnt[k] = (nill > 0) ? 1 : 0;
            end else begin
                m_vec[k] = m_vec[k] | bad;
                if (nill > 0 && m_cnt[k] < 15) m_cnt[k] = m_cnt[k] + 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (qn_on) begin
            for (int k = 0; k < 3; k++) begin
                n_chk++;
                if (qn[k] !== ~q[k])
                    $display("FAIL qn_inv p%0d: qn=%b q=%b", k, qn[k], q[k]);
                else
                    n_pass++;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; mode = 2'b11; s = 4'hF; r = 4'hF;
        err_clr = 1'b0;
        tick();
        rst = 1'b0;
        qn_on = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (q[k] !== 4'b0000 || qn[k] !== 4'b1111 ||
                ev[k] !== 4'b0000 || ec[k] !== 4'd0)
                $display("FAIL reset p%0d: q=%b qn=%b ev=%b cnt=%0d want 0000/1111/0000/0",
                         k, q[k], qn[k], ev[k], ec[k]);
            else
                n_pass++;
        end
    endtask

    task automatic test_sr_basic();
        mode = 2'b00; en = 1'b1; s = 4'b0011; r = 4'b0000;
        tick();
        n_chk++;
        if (q[0] !== 4'b0011) $display("FAIL sr_set: q=%b want 0011", q[0]);
        else n_pass++;
        s = 4'b0000; r = 4'b0001;
        tick();
        n_chk++;
        if (q[0] !== 4'b0010) $display("FAIL sr_reset: q=%b want 0010", q[0]);
        else n_pass++;
        en = 1'b0; s = 4'b1111;
        tick();
        tick();
        n_chk++;
        if (q[0] !== 4'b0010) $display("FAIL en_hold: q=%b want 0010", q[0]);
        else n_pass++;
        en = 1'b1; s = 4'b0000;
    endtask

    task automatic test_sr_policy();
        logic [3:0] want[3];
        want[0] = 4'b0101; want[1] = 4'b0111; want[2] = 4'b0100;
        rst = 1'b1; tick(); rst = 1'b0;
        mode = 2'b10; s = 4'b0101; r = 4'b0000;
        tick();
        mode = 2'b00; s = 4'b0011; r = 4'b0011;
        tick();
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (q[k] !== want[k] || ev[k] !== 4'b0011 || ec[k] !== 4'd1)
                $display("FAIL sr_policy p%0d: q=%b ev=%b cnt=%0d want %b/0011/1",
                         k, q[k], ev[k], ec[k], want[k]);
            else
                n_pass++;
        end
        s = 4'b0000; r = 4'b0000;
    endtask

    task automatic test_jk_t();
        logic [3:0] jk_seq[3];
        logic [3:0] t_seq[2];
        jk_seq[0] = 4'b1111; jk_seq[1] = 4'b0000; jk_seq[2] = 4'b1111;
        t_seq[0] = 4'b0101; t_seq[1] = 4'b1111;
        rst = 1'b1; tick(); rst = 1'b0;
        mode = 2'b01; s = 4'b1111; r = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_chk++;
            if (q[0] !== jk_seq[c] || ec[0] !== 4'd0)
                $display("FAIL jk_toggle c%0d: q=%b cnt=%0d want %b/0",
                         c, q[0], ec[0], jk_seq[c]);
            else
                n_pass++;
        end
        mode = 2'b11; s = 4'b1010; r = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_chk++;
            if (q[0] !== t_seq[c])
                $display("FAIL t_toggle c%0d: q=%b want %b", c, q[0], t_seq[c]);
            else
                n_pass++;
        end
    endtask

    task automatic test_err_sat_clr();
        rst = 1'b1; tick(); rst = 1'b0;
        mode = 2'b00; en = 1'b1; s = 4'b0001; r = 4'b0001;
        for (int c = 0; c < 20; c++) tick();
        n_chk++;
        if (ec[0] !== 4'd15 || ev[0] !== 4'b0001)
            $display("FAIL err_sat: cnt=%0d ev=%b want 15/0001", ec[0], ev[0]);
        else
            n_pass++;
        err_clr = 1'b1; s = 4'b0000; r = 4'b0000;
        tick();
        n_chk++;
        if (ec[0] !== 4'd0 || ev[0] !== 4'b0000)
            $display("FAIL err_clr: cnt=%0d ev=%b want 0/0000", ec[0], ev[0]);
        else
            n_pass++;
        s = 4'b1000; r = 4'b1000;
        tick();
        n_chk++;
        if (ec[0] !== 4'd1 || ev[0] !== 4'b1000)
            $display("FAIL err_clr_new: cnt=%0d ev=%b want 1/1000", ec[0], ev[0]);
        else
            n_pass++;
        err_clr = 1'b0; s = 4'b0000; r = 4'b0000;
    endtask

    task automatic test_reset_wins();
        mode = 2'b10; en = 1'b1; s = 4'b1001;
        tick();
        n_chk++;
        if (q[0] !== 4'b1001) $display("FAIL d_load: q=%b want 1001", q[0]);
        else n_pass++;
        rst = 1'b1; s = 4'b1111;
        tick();
        rst = 1'b0;
        n_chk++;
        if (q[0] !== 4'b0000 || qn[0] !== 4'b1111)
            $display("FAIL reset_wins: q=%b qn=%b want 0000/1111", q[0], qn[0]);
        else
            n_pass++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst     = ($urandom_range(0, 39) == 0);
            en      = ($urandom_range(0, 4) != 0);
            err_clr = ($urandom_range(0, 9) == 0);
            mode    = 2'($urandom_range(0, 3));
            s       = 4'($urandom);
            r       = 4'($urandom);
            tick();
            for (int k = 0; k < 3; k++) begin
                n_chk++;
                if (q[k] !== m_q[k] || ev[k] !== m_vec[k] ||
                    ec[k] !== 4'(m_cnt[k]))
                    $display("FAIL random c%0d p%0d: q=%b ev=%b cnt=%0d want %b/%b/%0d",
                             c, k, q[k], ev[k], ec[k], m_q[k], m_vec[k], m_cnt[k]);
                else
                    n_pass++;
            end
        end
        rst = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'b00; s = '0; r = '0; err_clr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_q[k] = '0; m_vec[k] = '0; m_cnt[k] = 0;
        end
        test_reset();
        test_sr_basic();
        test_sr_policy();
        test_jk_t();
        test_err_sat_clr();
        test_reset_wins();
        test_random();
        @(negedge clk);
        qn_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
